// File: rtl/tbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light unit.
package tbird_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_T1     = 3'd1,
    ST_T2     = 3'd2,
    ST_T3     = 3'd3,
    ST_T0     = 3'd4,
    ST_HZ_ON  = 3'd5,
    ST_HZ_OFF = 3'd6
  } state_e;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_LEFT   = 2'd1;
  localparam logic [1:0] MODE_RIGHT  = 2'd2;
  localparam logic [1:0] MODE_HAZARD = 2'd3;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_1   = 3'b001;
  localparam logic [2:0] PAT_2   = 3'b011;
  localparam logic [2:0] PAT_3   = 3'b111;

  // Lamp pattern of the active side for each turn-sequence state.
  function automatic logic [2:0] turn_pat(input state_e s);
    logic [2:0] p;
    case (s)
      ST_T1:   p = PAT_1;
      ST_T2:   p = PAT_2;
      ST_T3:   p = PAT_3;
      ST_T0:   p = PAT_OFF;
      default: p = PAT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchronizer for asynchronous switch levels.
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sh_q[DEPTH-1];

endmodule

// File: rtl/tail_light_scheduler.sv
// Turn/hazard sequencer with fixed arbitration and a full-rate brake overlay
// for the six Thunderbird tail lamps.
module tail_light_scheduler
  import tbird_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] L,
  output logic [2:0] R,
  output logic [1:0] mode
);

  logic left_s, right_s, hazard_s, brake_s;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_left   (.clk(clk), .rst(rst), .d_i(left),   .q_o(left_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_right  (.clk(clk), .rst(rst), .d_i(right),  .q_o(right_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_hazard (.clk(clk), .rst(rst), .d_i(hazard), .q_o(hazard_s));
  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_brake  (.clk(clk), .rst(rst), .d_i(brake),  .q_o(brake_s));

  state_e     state_q, state_d;
  logic [1:0] side_q, side_d;
  logic [2:0] l_q, l_d, r_q, r_d;
  logic [1:0] mode_q, mode_d;

  // The outputs run every clock so the brake overlay is not gated by clk_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      side_q  <= MODE_LEFT;
      l_q     <= PAT_OFF;
      r_q     <= PAT_OFF;
      mode_q  <= MODE_IDLE;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      l_q     <= l_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    if (clk_en) begin
      case (state_q)
        ST_IDLE, ST_T0, ST_HZ_OFF: begin
          if (hazard_s || (left_s && right_s)) begin
            state_d = ST_HZ_ON;
          end else if (left_s) begin
            state_d = ST_T1;
            side_d  = MODE_LEFT;
          end else if (right_s) begin
            state_d = ST_T1;
            side_d  = MODE_RIGHT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_T1:     state_d = hazard_s ? ST_HZ_ON : ST_T2;
        ST_T2:     state_d = hazard_s ? ST_HZ_ON : ST_T3;
        ST_T3:     state_d = hazard_s ? ST_HZ_ON : ST_T0;
        ST_HZ_ON:  state_d = ST_HZ_OFF;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Decode from next-state so lamps move on the same edge as the state.
  always_comb begin
    logic [2:0] brk_pat;
    brk_pat = brake_s ? PAT_3 : PAT_OFF;
    l_d     = PAT_OFF;
    r_d     = PAT_OFF;
    mode_d  = MODE_IDLE;
    case (state_d)
      ST_IDLE: begin
        l_d    = brk_pat;
        r_d    = brk_pat;
        mode_d = MODE_IDLE;
      end
      ST_T1, ST_T2, ST_T3, ST_T0: begin
        if (side_d == MODE_RIGHT) begin
          r_d = turn_pat(state_d);
          l_d = brk_pat;
        end else begin
          l_d = turn_pat(state_d);
          r_d = brk_pat;
        end
        mode_d = side_d;
      end
      ST_HZ_ON: begin
        l_d    = PAT_3;
        r_d    = PAT_3;
        mode_d = MODE_HAZARD;
      end
      ST_HZ_OFF: begin
        l_d    = PAT_OFF;
        r_d    = PAT_OFF;
        mode_d = MODE_HAZARD;
      end
      default: begin
        l_d    = PAT_OFF;
        r_d    = PAT_OFF;
        mode_d = MODE_IDLE;
      end
    endcase
  end

  assign L    = l_q;
  assign R    = r_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_tail_light_scheduler.sv
// Directed self-checking bench for tail_light_scheduler.
module tb_tail_light_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic [2:0] L, R;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  tail_light_scheduler #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .left(left), .right(right), .hazard(hazard), .brake(brake),
    .L(L), .R(R), .mode(mode)
  );

  always #5 clk = ~clk;

  // One clk_en pulse covering exactly one rising edge; returns at a falling edge.
  task automatic step_en();
    @(negedge clk) clk_en = 1'b1;
    @(negedge clk) clk_en = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(2);
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b000, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: L=%b R=%b mode=%0d, want 000 000 0", L, R, mode);
    end
    rst = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_left();
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b111; seq[3] = 3'b000;
    left = 1'b1;
    wait_clks(3);
    for (int i = 0; i < 8; i++) begin
      step_en();
      n_checks++;
      if ({L, R, mode} !== {seq[i % 4], 3'b000, 2'd1}) begin
        n_fail++;
        $display("FAIL left_step%0d: L=%b R=%b mode=%0d, want %b 000 1", i, L, R, mode, seq[i % 4]);
      end
      wait_clks(3);
    end
    left = 1'b0;
    wait_clks(3);
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b000, 2'd0}) begin
      n_fail++;
      $display("FAIL left_to_idle: L=%b R=%b mode=%0d, want 000 000 0", L, R, mode);
    end
  endtask

  task automatic test_hazard_preempt();
    right = 1'b1;
    wait_clks(3);
    step_en();
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b011, 2'd2}) begin
      n_fail++;
      $display("FAIL right_t2: L=%b R=%b mode=%0d, want 000 011 2", L, R, mode);
    end
    hazard = 1'b1;
    wait_clks(3);
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b011, 2'd2}) begin
      n_fail++;
      $display("FAIL hold_without_en: L=%b R=%b mode=%0d, want 000 011 2", L, R, mode);
    end
    for (int i = 0; i < 3; i++) begin
      step_en();
      n_checks++;
      if ((i % 2) == 0) begin
        if ({L, R, mode} !== {3'b111, 3'b111, 2'd3}) begin
          n_fail++;
          $display("FAIL hz_on%0d: L=%b R=%b mode=%0d, want 111 111 3", i, L, R, mode);
        end
      end else begin
        if ({L, R, mode} !== {3'b000, 3'b000, 2'd3}) begin
          n_fail++;
          $display("FAIL hz_off%0d: L=%b R=%b mode=%0d, want 000 000 3", i, L, R, mode);
        end
      end
    end
    hazard = 1'b0;
    right  = 1'b0;
    wait_clks(3);
    step_en();
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b000, 2'd0}) begin
      n_fail++;
      $display("FAIL hz_to_idle: L=%b R=%b mode=%0d, want 000 000 0", L, R, mode);
    end
  endtask

  task automatic test_simultaneous();
    left  = 1'b1;
    right = 1'b1;
    wait_clks(3);
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b111, 3'b111, 2'd3}) begin
      n_fail++;
      $display("FAIL simul_on: L=%b R=%b mode=%0d, want 111 111 3", L, R, mode);
    end
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b000, 2'd3}) begin
      n_fail++;
      $display("FAIL simul_off: L=%b R=%b mode=%0d, want 000 000 3", L, R, mode);
    end
    left  = 1'b0;
    right = 1'b0;
    wait_clks(3);
    step_en();
  endtask

  task automatic test_brake();
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b111; seq[3] = 3'b000;
    brake = 1'b1;
    wait_clks(2);
    n_checks++;
    if (L !== 3'b000) begin
      n_fail++;
      $display("FAIL brake_early: L=%b, want 000", L);
    end
    wait_clks(1);
    n_checks++;
    if ({L, R, mode} !== {3'b111, 3'b111, 2'd0}) begin
      n_fail++;
      $display("FAIL brake_idle: L=%b R=%b mode=%0d, want 111 111 0", L, R, mode);
    end
    left = 1'b1;
    wait_clks(3);
    for (int i = 0; i < 4; i++) begin
      step_en();
      n_checks++;
      if ({L, R, mode} !== {seq[i], 3'b111, 2'd1}) begin
        n_fail++;
        $display("FAIL brake_left%0d: L=%b R=%b mode=%0d, want %b 111 1", i, L, R, mode, seq[i]);
      end
    end
    left = 1'b0;
    hazard = 1'b1;
    wait_clks(3);
    step_en();
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b000, 2'd3}) begin
      n_fail++;
      $display("FAIL brake_hz_off: L=%b R=%b mode=%0d, want 000 000 3", L, R, mode);
    end
    hazard = 1'b0;
    wait_clks(3);
    step_en();
    n_checks++;
    if ({L, R, mode} !== {3'b111, 3'b111, 2'd0}) begin
      n_fail++;
      $display("FAIL brake_back_idle: L=%b R=%b mode=%0d, want 111 111 0", L, R, mode);
    end
    brake = 1'b0;
    wait_clks(3);
    n_checks++;
    if ({L, R} !== {3'b000, 3'b000}) begin
      n_fail++;
      $display("FAIL brake_release: L=%b R=%b, want 000 000", L, R);
    end
  endtask

  task automatic test_left_release();
    logic [2:0] seq [4];
    seq[0] = 3'b011; seq[1] = 3'b111; seq[2] = 3'b000; seq[3] = 3'b000;
    left = 1'b1;
    wait_clks(3);
    step_en();
    n_checks++;
    if ({L, mode} !== {3'b001, 2'd1}) begin
      n_fail++;
      $display("FAIL release_t1: L=%b mode=%0d, want 001 1", L, mode);
    end
    left = 1'b0;
    wait_clks(3);
    for (int i = 0; i < 4; i++) begin
      step_en();
      n_checks++;
      if ({L, R, mode} !== {seq[i], 3'b000, (i == 3) ? 2'd0 : 2'd1}) begin
        n_fail++;
        $display("FAIL release_step%0d: L=%b R=%b mode=%0d, want %b 000 %0d",
                 i, L, R, mode, seq[i], (i == 3) ? 0 : 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b011; seq[2] = 3'b111; seq[3] = 3'b000;
    right = 1'b1;
    wait_clks(3);
    clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({L, R, mode} !== {3'b000, seq[i], 2'd2}) begin
        n_fail++;
        $display("FAIL held_en%0d: L=%b R=%b mode=%0d, want 000 %b 2", i, L, R, mode, seq[i]);
      end
    end
    clk_en = 1'b0;
    right  = 1'b0;
    wait_clks(3);
    step_en();
  endtask

  task automatic test_reset_mid();
    left = 1'b1;
    wait_clks(3);
    step_en();
    step_en();
    n_checks++;
    if (L !== 3'b011) begin
      n_fail++;
      $display("FAIL mid_pre: L=%b, want 011", L);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({L, R, mode} !== {3'b000, 3'b000, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: L=%b R=%b mode=%0d, want 000 000 0", L, R, mode);
    end
    left = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(2);
  endtask

  initial begin
    test_reset();
    test_left();
    test_hazard_preempt();
    test_simultaneous();
    test_brake();
    test_left_release();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
